// File: rtl/uart_tx_cfg.sv
// Run-time configurable UART transmitter (data bits, parity, stop bits chosen per frame).
// Optional parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg #(
    parameter int DBIT_MAX = 8,
    parameter int OS       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_tick,
    input  logic                tx_start,
    input  logic [DBIT_MAX-1:0] din,
    input  logic [3:0]          cfg_dbits,
    input  logic                cfg_stop2,
    input  logic                cfg_par_en,
    input  logic                cfg_par_odd,
    output logic                tx_ready,
    output logic                tx_busy,
    output logic                tx_done_tick,
    output logic                tx
);

    localparam int SW = $clog2(2 * OS);
    localparam int NW = $clog2(DBIT_MAX + 1);
    localparam logic [SW-1:0] OS_LAST    = SW'(OS - 1);
    localparam logic [SW-1:0] STOP2_LAST = SW'(2 * OS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic                tx_q, tx_d;
    logic [DBIT_MAX-1:0] b_q, b_d;
    logic [NW-1:0]       dbits_q;
    logic                stop2_q;
    logic                load;
    logic                done;

    // Out-of-range widths fall back to the full data width.
    function automatic logic [NW-1:0] clamp_dbits(input logic [3:0] d);
        if (int'(d) < 5 || int'(d) > DBIT_MAX) return NW'(DBIT_MAX);
        return NW'(d);
    endfunction

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_q;

    function automatic logic frame_parity(input logic [DBIT_MAX-1:0] d,
                                          input logic [NW-1:0] nb,
                                          input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (i < int'(nb)) p = p ^ d[i];
        end
        return p;
    endfunction
`else
    logic unused_par;
    assign unused_par = cfg_par_en | cfg_par_odd;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            tx_q    <= tx_d;
        end
    end

    // Frame data and settings are snapshotted at accept and never follow the inputs afterwards.
    always_ff @(posedge clk) begin
        if (load) begin
            b_q      <= din;
            dbits_q  <= clamp_dbits(cfg_dbits);
            stop2_q  <= cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q <= cfg_par_en;
            par_q    <= frame_parity(din, clamp_dbits(cfg_dbits), cfg_par_odd);
`endif
        end else begin
            b_q <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        tx_d    = tx_q;
        b_d     = b_q;
        load    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    load    = 1'b1;
                    state_d = S_START;
                    s_d     = '0;
                    n_d     = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        state_d = S_DATA;
                        s_d     = '0;
                        tx_d    = b_q[0];
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        s_d = '0;
                        if (n_q == dbits_q - NW'(1)) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state_d = S_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
`else
                            state_d = S_STOP;
                            tx_d    = 1'b1;
`endif
                        end else begin
                            n_d  = n_q + NW'(1);
                            b_d  = b_q >> 1;
                            tx_d = b_q[1];
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (s_q == OS_LAST) begin
                        state_d = S_STOP;
                        s_d     = '0;
                        tx_d    = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (s_q == (stop2_q ? STOP2_LAST : OS_LAST)) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                        s_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_ready     = (state_q == S_IDLE);
    assign tx_busy      = ~tx_ready;
    assign tx_done_tick = done;
    assign tx           = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frame table, corner sequences and
// randomized frames against a bit-list reference model.
module tb_uart_tx_cfg;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic [3:0] cfg_dbits;
    logic       cfg_stop2;
    logic       cfg_par_en;
    logic       cfg_par_odd;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    int checks = 0;
    int errors = 0;

    uart_tx_cfg #(.DBIT_MAX(8), .OS(OS)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
        .cfg_dbits(cfg_dbits), .cfg_stop2(cfg_stop2), .cfg_par_en(cfg_par_en),
        .cfg_par_odd(cfg_par_odd), .tx_ready(tx_ready), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .tx(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  nb;
        logic        st2;
        logic        pe;
        logic        po;
        logic [15:0] eb;
        int          en;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: list of line levels, one per bit period, in transmission order.
    function automatic void model(input logic [7:0] d, input logic [3:0] nb, input logic st2,
                                  input logic pe, input logic po,
                                  output logic [15:0] eb, output int en);
        int n;
        int k;
        logic p;
        n  = (nb < 5 || nb > 8) ? 8 : int'(nb);
        eb = '0;
        k  = 1;
        p  = po;
        for (int i = 0; i < n; i++) begin
            eb[k] = d[i];
            p     = p ^ d[i];
            k++;
        end
`ifdef UART_TX_PARITY_EN
        if (pe) begin
            eb[k] = p;
            k++;
        end
`else
        p = p & pe;
`endif
        eb[k] = 1'b1;
        k++;
        if (st2) begin
            eb[k] = 1'b1;
            k++;
        end
        en = k;
    endfunction

    // Called just after a rising edge with the DUT idle.
    task automatic run_frame(input logic [7:0] d, input logic [3:0] nb, input logic st2,
                             input logic pe, input logic po, input logic [15:0] eb,
                             input int en, input bit hold, input bit poke, input string nm);
        int j;
        int cyc;
        int nbad;
        int ndone;
        int len;
        bit exp_done;
        chk({nm, " ready before"}, {tx_ready, tx}, 2'b11);
        din         = d;
        cfg_dbits   = nb;
        cfg_stop2   = st2;
        cfg_par_en  = pe;
        cfg_par_odd = po;
        tx_start    = 1'b1;
        s_tick      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        chk({nm, " accept"}, {tx, tx_ready, tx_busy}, 3'b001);
        if (!hold) tx_start = 1'b0;
        din         = 8'($urandom);
        cfg_dbits   = 4'($urandom);
        cfg_stop2   = 1'($urandom);
        cfg_par_en  = 1'($urandom);
        cfg_par_odd = 1'($urandom);
        len   = en * OS;
        j     = 0;
        cyc   = 0;
        nbad  = 0;
        ndone = 0;
        while (j < len && cyc < 4000) begin
            s_tick = ($urandom_range(0, 2) != 0);
            if (poke && j == 3 * OS + 5) begin
                tx_start = 1'b1;
                din      = 8'h00;
            end else if (!hold) begin
                tx_start = 1'b0;
            end
            @(negedge clk);
            exp_done = s_tick && (j + 1 == len);
            if (tx !== eb[j / OS]) nbad++;
            if (tx_done_tick !== exp_done) nbad++;
            if (tx_ready !== 1'b0 || tx_busy !== 1'b1) nbad++;
            if (tx_done_tick === 1'b1) ndone++;
            if (s_tick) j++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, " tick mismatches"}, nbad, 0);
        chk({nm, " done pulses"}, ndone, 1);
        chk({nm, " ticks sent"}, j, len);
        chk({nm, " idle after"}, {tx_ready, tx_busy, tx_done_tick, tx}, 4'b1001);
    endtask

    vec_t       tbl[5];
    logic [7:0] rd;
    logic [3:0] rnb;
    logic       rst2, rpe, rpo;
    logic [15:0] reb;
    int         ren;
    int         nd;
    bit         rhold;

    initial begin
        tbl[0] = '{8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 16'h034A, 10};
        tbl[1] = '{8'h3C, 4'd3, 1'b0, 1'b0, 1'b0, 16'h0278, 10};
`ifdef UART_TX_PARITY_EN
        tbl[2] = '{8'h41, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0682, 11};
        tbl[3] = '{8'hFF, 4'd5, 1'b0, 1'b1, 1'b1, 16'h00BE, 8};
        tbl[4] = '{8'h2D, 4'd6, 1'b1, 1'b1, 1'b1, 16'h03DA, 10};
`else
        tbl[2] = '{8'h41, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0382, 10};
        tbl[3] = '{8'hFF, 4'd5, 1'b0, 1'b1, 1'b1, 16'h007E, 7};
        tbl[4] = '{8'h2D, 4'd6, 1'b1, 1'b1, 1'b1, 16'h01DA, 9};
`endif
        reset = 1'b1; s_tick = 1'b0; tx_start = 1'b0; din = '0;
        cfg_dbits = 4'd8; cfg_stop2 = 1'b0; cfg_par_en = 1'b0; cfg_par_odd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset tx", tx, 1'b1);
        chk("reset ready", tx_ready, 1'b1);
        chk("reset busy", tx_busy, 1'b0);
        chk("reset done", tx_done_tick, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed table; first entry also gets an ignored mid-DATA tx_start with din=0.
        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].din, tbl[i].nb, tbl[i].st2, tbl[i].pe, tbl[i].po,
                      tbl[i].eb, tbl[i].en, 1'b0, (i == 0), $sformatf("vec%0d", i));
        end

        // Back-to-back 0x55 frames with tx_start held high.
        model(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, reb, ren);
        chk("model 0x55 length", ren, 10);
        run_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, reb, ren, 1'b1, 1'b0, "b2b first");
        run_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, reb, ren, 1'b0, 1'b0, "b2b second");

        // Reset during data bit 4 of 0xA5 (a 0 bit) aborts the frame.
        din = 8'hA5; cfg_dbits = 4'd8; cfg_stop2 = 1'b0; cfg_par_en = 1'b0;
        tx_start = 1'b1; s_tick = 1'b0;
        @(posedge clk); #1;
        tx_start = 1'b0; s_tick = 1'b1;
        repeat (5 * OS + 3) @(posedge clk);
        #1;
        chk("pre-reset data bit4", {tx, tx_busy}, 2'b01);
        #2 reset = 1'b1;
        #1;
        chk("async reset state", {tx, tx_ready, tx_busy, tx_done_tick}, 4'b1100);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 12 * OS; c++) begin
            @(negedge clk);
            if (tx_done_tick !== 1'b0 || tx !== 1'b1 || tx_ready !== 1'b1) nd++;
        end
        chk("after abort stays idle", nd, 0);
        s_tick = 1'b0;
        @(posedge clk); #1;

        // Randomized frames, including illegal widths and held tx_start.
        for (int r = 0; r < 30; r++) begin
            rd    = 8'($urandom);
            rnb   = 4'($urandom_range(0, 15));
            rst2  = 1'($urandom);
            rpe   = 1'($urandom);
            rpo   = 1'($urandom);
            rhold = (r != 29) && ($urandom_range(0, 3) == 0);
            model(rd, rnb, rst2, rpe, rpo, reb, ren);
            run_frame(rd, rnb, rst2, rpe, rpo, reb, ren, rhold, 1'b0,
                      $sformatf("rand%0d", r));
            if (!rhold) begin
                repeat ($urandom_range(0, 3)) begin
                    s_tick = 1'($urandom);
                    @(posedge clk); #1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
